axi_lite_reg_slave: RTL and testbench

- AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers to a bus master, such as the AXI4-Lite master BFM inside the test block design.
- Sits behind the interconnect, which decodes the base address; this block decodes only the low offset bits.
- Register contents and per-register write pulses are exported to user logic.
- Independent write and read channel FSMs; write address and write data are accepted in either order.

---
 rtl/axi_lite_reg_slave.sv | 213 +++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave
//
// AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers. The
// interconnect has already decoded the base address. Only the low
// OFFSET_WIDTH address bits are decoded here: index = offset >> 2.
//
// Ports:
//   ACLK, ARESET           clock (rising edge), asynchronous active-high reset
//   S_AXI_AW*              write address channel (AWPROT ignored)
//   S_AXI_W*               write data channel with byte strobes
//   S_AXI_B*               write response channel (OKAY / SLVERR)
//   S_AXI_AR*              read address channel (ARPROT ignored)
//   S_AXI_R*               read data channel (OKAY / SLVERR)
//   reg_out                register contents, reg i at [32i+31:32i]
//   reg_wr_pulse           one-cycle pulse per register write commit
//
// Handshake semantics: a transfer happens on a rising edge where VALID and
// READY are both high. A source holds VALID and its payload stable until that
// edge. This block never makes its READY depend on the matching VALID.
// AWREADY, WREADY and ARREADY are forced low while ARESET is high.

module axi_lite_reg_slave #(
    parameter int NUM_REGS     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 12
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int IDX_W = OFFSET_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [31:0]      regs [NUM_REGS];
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic             aw_hs, w_hs, ar_hs;
    logic             commit;
    logic [IDX_W-1:0] commit_idx;
    logic [31:0]      commit_data;
    logic [3:0]       commit_strb;
    logic             commit_in_range;

    logic [IDX_W-1:0] ar_idx;
    logic             ar_in_range;
    logic [31:0]      rd_mux;

    // Address bits outside the decoded offset, the byte-lane bits and the
    // protection fields carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_WIDTH-1:OFFSET_WIDTH], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[ADDR_WIDTH-1:OFFSET_WIDTH], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;

        S_AXI_AWREADY = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_W);
        S_AXI_WREADY  = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_AW);
        aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs          = S_AXI_WVALID && S_AXI_WREADY;

        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_state_next = W_RESP;
                else if (aw_hs)    w_state_next = W_HAVE_AW;
                else if (w_hs)     w_state_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)         w_state_next = W_RESP;
            W_HAVE_W:  if (aw_hs)        w_state_next = W_RESP;
            W_RESP:    if (S_AXI_BREADY) w_state_next = W_IDLE;
            default:                     w_state_next = W_IDLE;
        endcase
    end

    assign S_AXI_BVALID = (w_state == W_RESP);

    // The commit edge is the one that enters W_RESP. Whichever half arrived
    // earlier comes from its capture register; the other comes from the bus.
    assign commit          = (w_state != W_RESP) && (w_state_next == W_RESP);
    assign commit_idx      = (w_state == W_HAVE_AW) ? aw_idx_q : S_AXI_AWADDR[OFFSET_WIDTH-1:2];
    assign commit_data     = (w_state == W_HAVE_W)  ? wdata_q  : S_AXI_WDATA;
    assign commit_strb     = (w_state == W_HAVE_W)  ? wstrb_q  : S_AXI_WSTRB;
    assign commit_in_range = (commit_idx < IDX_W'(NUM_REGS));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            S_AXI_BRESP  <= RESP_OKAY;
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[OFFSET_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                S_AXI_BRESP <= commit_in_range ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (commit_idx == IDX_W'(i)) begin
                        // Pulse fires even with all strobes low.
                        reg_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (commit_strb[b]) regs[i][8*b +: 8] <= commit_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_state_next;
    end

    always_comb begin
        r_state_next  = r_state;
        S_AXI_ARREADY = !ARESET && (r_state == R_IDLE);
        ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
        case (r_state)
            R_IDLE:  if (ar_hs)        r_state_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_next = R_IDLE;
            default:                   r_state_next = R_IDLE;
        endcase
    end

    assign S_AXI_RVALID = (r_state == R_DATA);
    assign ar_idx       = S_AXI_ARADDR[OFFSET_WIDTH-1:2];
    assign ar_in_range  = (ar_idx < IDX_W'(NUM_REGS));

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) rd_mux = regs[i];
        end
    end

    // Sampling regs on the AR edge returns the pre-write value when a write
    // commit to the same register lands on the same edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RDATA <= ar_in_range ? rd_mux : 32'h0;
            S_AXI_RRESP <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave
//
// Directed bench for axi_lite_reg_slave with NUM_REGS=4. Expected values are
// hand-computed constants plus a small register model updated by byte strobe.

`timescale 1ns/1ps

module tb_axi_lite_reg_slave;

    localparam int NUM_REGS = 4;
    localparam int AW       = 32;

    // ---------------- clock / reset ----------------
    logic tb_ACLK = 1'b0;
    logic tb_ARESET;
    always #5 tb_ACLK = ~tb_ACLK;

    logic [AW-1:0]            s_axi_awaddr;
    logic [2:0]               s_axi_awprot;
    logic                     s_axi_awvalid;
    logic                     s_axi_awready;
    logic [31:0]              s_axi_wdata;
    logic [3:0]               s_axi_wstrb;
    logic                     s_axi_wvalid;
    logic                     s_axi_wready;
    logic [1:0]               s_axi_bresp;
    logic                     s_axi_bvalid;
    logic                     s_axi_bready;
    logic [AW-1:0]            s_axi_araddr;
    logic [2:0]               s_axi_arprot;
    logic                     s_axi_arvalid;
    logic                     s_axi_arready;
    logic [31:0]              s_axi_rdata;
    logic [1:0]               s_axi_rresp;
    logic                     s_axi_rvalid;
    logic                     s_axi_rready;
    logic [NUM_REGS*32-1:0]   reg_out;
    logic [NUM_REGS-1:0]      reg_wr_pulse;

    axi_lite_reg_slave #(
        .NUM_REGS     (NUM_REGS),
        .ADDR_WIDTH   (AW),
        .OFFSET_WIDTH (12)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESET        (tb_ARESET),
        .S_AXI_AWADDR  (s_axi_awaddr),
        .S_AXI_AWPROT  (s_axi_awprot),
        .S_AXI_AWVALID (s_axi_awvalid),
        .S_AXI_AWREADY (s_axi_awready),
        .S_AXI_WDATA   (s_axi_wdata),
        .S_AXI_WSTRB   (s_axi_wstrb),
        .S_AXI_WVALID  (s_axi_wvalid),
        .S_AXI_WREADY  (s_axi_wready),
        .S_AXI_BRESP   (s_axi_bresp),
        .S_AXI_BVALID  (s_axi_bvalid),
        .S_AXI_BREADY  (s_axi_bready),
        .S_AXI_ARADDR  (s_axi_araddr),
        .S_AXI_ARPROT  (s_axi_arprot),
        .S_AXI_ARVALID (s_axi_arvalid),
        .S_AXI_ARREADY (s_axi_arready),
        .S_AXI_RDATA   (s_axi_rdata),
        .S_AXI_RRESP   (s_axi_rresp),
        .S_AXI_RVALID  (s_axi_rvalid),
        .S_AXI_RREADY  (s_axi_rready),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model [NUM_REGS];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    function automatic logic [NUM_REGS*32-1:0] model_packed();
        logic [NUM_REGS*32-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // W is presented at once; AW follows aw_delay cycles later (0 = together).
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay, input int bready_delay,
                             input logic [1:0] exp_resp, input logic [NUM_REGS-1:0] exp_pulse);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        cyc = 0; aw_done = 0; w_done = 0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        s_axi_awvalid = (aw_delay == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge tb_ACLK); #1;
            cyc++;
            if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; s_axi_wvalid  = 1'b0; end
            if (!aw_done && cyc >= aw_delay) s_axi_awvalid = 1'b1;
            if (w_done && !aw_done) check("wready_after_w", s_axi_wready, 1'b0);
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("aw_w_timeout", 1'b0, 1'b1);
        check("bvalid_on_commit", s_axi_bvalid, 1'b1);
        check("bresp", s_axi_bresp, exp_resp);
        check("wr_pulse", reg_wr_pulse, exp_pulse);
        check("reg_out_on_bvalid", reg_out, model_packed());
        for (int k = 0; k < bready_delay; k++) begin
            @(posedge tb_ACLK); #1;
            check("bvalid_hold", s_axi_bvalid, 1'b1);
            check("bresp_hold", s_axi_bresp, exp_resp);
            check("awready_in_resp", s_axi_awready, 1'b0);
            check("pulse_one_cycle", reg_wr_pulse, '0);
        end
        s_axi_bready = 1'b1;
        @(posedge tb_ACLK); #1;
        s_axi_bready = 1'b0;
        check("bvalid_clear", s_axi_bvalid, 1'b0);
        check("pulse_clear", reg_wr_pulse, '0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rready_delay,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int cyc;
        bit done, hs;
        cyc = 0; done = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!done && cyc < 50) begin
            hs = s_axi_arvalid && s_axi_arready;
            @(posedge tb_ACLK); #1;
            cyc++;
            if (hs) done = 1;
        end
        s_axi_arvalid = 1'b0;
        if (!done) check("ar_timeout", 1'b0, 1'b1);
        check("rvalid_latency", s_axi_rvalid, 1'b1);
        check("rdata", s_axi_rdata, exp_data);
        check("rresp", s_axi_rresp, exp_resp);
        for (int k = 0; k < rready_delay; k++) begin
            @(posedge tb_ACLK); #1;
            check("rvalid_hold", s_axi_rvalid, 1'b1);
            check("rdata_hold", s_axi_rdata, exp_data);
            check("rresp_hold", s_axi_rresp, exp_resp);
        end
        s_axi_rready = 1'b1;
        @(posedge tb_ACLK); #1;
        s_axi_rready = 1'b0;
        check("rvalid_clear", s_axi_rvalid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] seq_data [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    logic [NUM_REGS-1:0] one_hot;

    initial begin
        tb_ARESET     = 1'b1;
        s_axi_awaddr  = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0; s_axi_wstrb  = '0; s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        // Reset held 25 cycles, observed mid-way.
        repeat (10) @(posedge tb_ACLK);
        #1;
        check("rst_awready", s_axi_awready, 1'b0);
        check("rst_wready",  s_axi_wready,  1'b0);
        check("rst_arready", s_axi_arready, 1'b0);
        check("rst_bvalid",  s_axi_bvalid,  1'b0);
        check("rst_rvalid",  s_axi_rvalid,  1'b0);
        check("rst_reg_out", reg_out, '0);
        check("rst_pulse",   reg_wr_pulse, '0);
        check("rst_rdata",   s_axi_rdata, 32'h0);
        repeat (15) @(posedge tb_ACLK);
        #1;
        tb_ARESET = 1'b0;
        @(posedge tb_ACLK); #1;
        check("post_rst_awready", s_axi_awready, 1'b1);
        check("post_rst_wready",  s_axi_wready,  1'b1);
        check("post_rst_arready", s_axi_arready, 1'b1);

        // Sequential write / readback.
        for (int i = 0; i < 4; i++) begin
            model[i] = seq_data[i];
            one_hot  = NUM_REGS'(1) << i;
            axi_write(32'(4 * i), seq_data[i], 4'hF, 0, 0, 2'b00, one_hot);
            axi_read(32'(4 * i), 0, seq_data[i], 2'b00);
        end

        // W leads AW by 3 cycles.
        model[1] = 32'h12345678;
        axi_write(32'h4, 32'h12345678, 4'hF, 3, 0, 2'b00, 4'b0010);
        axi_read(32'h4, 0, 32'h12345678, 2'b00);

        // Partial strobes: bytes 0 and 2 of 0xDEAD0011.
        model[2] = merge(model[2], 32'hFFFFFFFF, 4'b0101);
        axi_write(32'h8, 32'hFFFFFFFF, 4'b0101, 0, 0, 2'b00, 4'b0100);
        axi_read(32'h8, 0, 32'hDEFF00FF, 2'b00);

        // Zero strobes: pulse fires, register holds.
        axi_write(32'hC, 32'h00000000, 4'b0000, 0, 0, 2'b00, 4'b1000);
        axi_read(32'hC, 0, 32'hBEEF0011, 2'b00);

        // Out of range.
        axi_write(32'h10, 32'hCAFEBABE, 4'hF, 0, 0, 2'b10, 4'b0000);
        axi_read(32'h10, 0, 32'h0, 2'b10);
        axi_read(32'h00000FF0, 0, 32'h0, 2'b10);

        // Upper address bits and byte-lane bits ignored.
        axi_read(32'hABCD1005, 0, 32'h12345678, 2'b00);

        // Back-pressure on B and R.
        model[0] = 32'h00000077;
        axi_write(32'h0, 32'h00000077, 4'hF, 0, 3, 2'b00, 4'b0001);
        axi_read(32'h0, 4, 32'h00000077, 2'b00);

        // Collision: AR and write commit to reg0 on the same edge.
        model[0]      = 32'h00000055;
        s_axi_awaddr  = 32'h0; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1;  s_axi_wvalid = 1'b1;
        s_axi_araddr  = 32'h0; s_axi_arvalid = 1'b1;
        @(posedge tb_ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("coll_bvalid", s_axi_bvalid, 1'b1);
        check("coll_rvalid", s_axi_rvalid, 1'b1);
        check("coll_rdata_old", s_axi_rdata, 32'h00000077);
        check("coll_rresp", s_axi_rresp, 2'b00);
        check("coll_bresp", s_axi_bresp, 2'b00);
        check("coll_reg_out", reg_out, model_packed());
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(posedge tb_ACLK); #1;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        check("coll_bvalid_clear", s_axi_bvalid, 1'b0);
        check("coll_rvalid_clear", s_axi_rvalid, 1'b0);
        axi_read(32'h0, 0, 32'h00000055, 2'b00);

        // ---------------- final report ----------------
        check("final_reg_out", reg_out, model_packed());
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
